// File: rtl/xgmii_frame_tx.sv
// AXI-stream to XGMII transmit framer for 32-bit (4-lane) or 64-bit (8-lane) XGMII.
// Adds start/preamble/SFD, the terminate character and a minimum inter-frame gap, and
// ends a frame with /E/ on source underflow or tuser. Every output is a flop.
// Define XGMII_FRAME_TX_STATS_EN to build the good-frame and error counters; without it
// stat_frames and stat_errors are tied to zero.
module xgmii_frame_tx #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned N_IFG      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CTRL_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] xgmii_txd,
  output logic [CTRL_WIDTH-1:0] xgmii_txc,
  output logic [31:0]           stat_frames,
  output logic [15:0]           stat_errors
);

  localparam int unsigned CntW = $clog2(CTRL_WIDTH + 1);
  localparam logic [7:0] IdleCh = 8'h07;
  localparam logic [7:0] TermCh = 8'hFD;
  localparam logic [7:0] ErrCh  = 8'hFE;
  // Lane 0 is the least significant byte: FB 55 55 55 55 55 55 D5 on the wire.
  localparam logic [63:0] PreamblePair = 64'hD5555555_555555FB;
  localparam logic [DATA_WIDTH-1:0] PreWord0 = PreamblePair[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] PreWord1 = PreamblePair[63:64-DATA_WIDTH];
  localparam logic [CTRL_WIDTH-1:0] PreCtl0  = {{(CTRL_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] IdleWord = {CTRL_WIDTH{IdleCh}};
  localparam logic [DATA_WIDTH-1:0] ErrWord  = {CTRL_WIDTH{ErrCh}};
  localparam bit OneWordPre = (DATA_WIDTH == 64);

  typedef enum logic [2:0] {StIdle, StPre, StData, StTerm, StDrop, StIfg} state_e;

  state_e                state;
  logic [6:0]            ifg_cnt;    // gap bytes already on the wire, saturating at 127
  logic                  term_user;  // tuser of a full-width last beat, used by TERM
  logic [CntW-1:0]       keep_n;
  logic [DATA_WIDTH-1:0] beat_txd;
  logic [CTRL_WIDTH-1:0] beat_txc;
  logic [7:0]            ifg_sum;
  logic [6:0]            ifg_inc;
  logic                  ifg_ok;

  // Shape the incoming beat: data lanes, then the terminate character and idle fill.
  always_comb begin
    keep_n = '0;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      keep_n = keep_n + CntW'(s_axis_tkeep[i]);
    end
    if (!s_axis_tlast) keep_n = CntW'(CTRL_WIDTH);
    beat_txd = s_axis_tdata;
    beat_txc = '0;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      if (CntW'(i) == keep_n) begin
        beat_txd[8*i +: 8] = s_axis_tuser ? ErrCh : TermCh;
        beat_txc[i]        = 1'b1;
      end else if (CntW'(i) > keep_n) begin
        beat_txd[8*i +: 8] = IdleCh;
        beat_txc[i]        = 1'b1;
      end
    end
  end

  // Saturating gap accumulator and the start-allowed test.
  always_comb begin
    ifg_sum = {1'b0, ifg_cnt} + 8'(CTRL_WIDTH);
    ifg_inc = ifg_sum[7] ? 7'd127 : ifg_sum[6:0];
    ifg_ok  = ifg_cnt >= 7'(N_IFG);
  end

  // Framing FSM with registered XGMII outputs and tready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      xgmii_txd     <= IdleWord;
      xgmii_txc     <= '1;
      s_axis_tready <= 1'b0;
      ifg_cnt       <= 7'd127;
      term_user     <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StIfg: begin
          xgmii_txd <= IdleWord;
          xgmii_txc <= '1;
          ifg_cnt   <= ifg_inc;
          if (ifg_ok) begin
            if (s_axis_tvalid) begin
              xgmii_txd <= PreWord0;
              xgmii_txc <= PreCtl0;
              // A single preamble word already carries the SFD, so data may follow at once.
              if (OneWordPre) begin
                state         <= StData;
                s_axis_tready <= 1'b1;
              end else begin
                state <= StPre;
              end
            end else begin
              state <= StIdle;
            end
          end
        end
        StPre: begin
          xgmii_txd     <= PreWord1;
          xgmii_txc     <= '0;
          s_axis_tready <= 1'b1;
          state         <= StData;
        end
        StData: begin
          if (s_axis_tvalid) begin
            xgmii_txd <= beat_txd;
            xgmii_txc <= beat_txc;
            if (s_axis_tlast) begin
              s_axis_tready <= 1'b0;
              term_user     <= s_axis_tuser;
              if (keep_n == CntW'(CTRL_WIDTH)) begin
                state <= StTerm;
              end else begin
                state   <= StIfg;
                ifg_cnt <= 7'(CTRL_WIDTH) - 7'(keep_n);
              end
            end
          end else begin
            // Source ran dry mid-frame: poison the frame and discard the rest of it.
            xgmii_txd <= ErrWord;
            xgmii_txc <= '1;
            state     <= StDrop;
          end
        end
        StTerm: begin
          xgmii_txd <= {IdleWord[DATA_WIDTH-1:8], term_user ? ErrCh : TermCh};
          xgmii_txc <= '1;
          ifg_cnt   <= 7'(CTRL_WIDTH);
          state     <= StIfg;
        end
        StDrop: begin
          xgmii_txd <= IdleWord;
          xgmii_txc <= '1;
          if (s_axis_tvalid && s_axis_tlast) begin
            s_axis_tready <= 1'b0;
            ifg_cnt       <= 7'(CTRL_WIDTH);
            state         <= StIfg;
          end
        end
        default: begin
          xgmii_txd     <= IdleWord;
          xgmii_txc     <= '1;
          s_axis_tready <= 1'b0;
          state         <= StIdle;
        end
      endcase
    end
  end

`ifdef XGMII_FRAME_TX_STATS_EN
  logic stat_good;
  logic stat_bad;

  // Decode the cycle whose edge registers a /T/ or an /E/ termination.
  always_comb begin
    stat_good = 1'b0;
    stat_bad  = 1'b0;
    if (state == StTerm) begin
      stat_good = !term_user;
      stat_bad  = term_user;
    end else if (state == StData) begin
      if (!s_axis_tvalid) begin
        stat_bad = 1'b1;
      end else if (s_axis_tlast && keep_n != CntW'(CTRL_WIDTH)) begin
        stat_good = !s_axis_tuser;
        stat_bad  = s_axis_tuser;
      end
    end
  end

  // Frame counter wraps; error counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames <= '0;
      stat_errors <= '0;
    end else begin
      if (stat_good) stat_frames <= stat_frames + 32'd1;
      if (stat_bad && stat_errors != 16'hFFFF) stat_errors <= stat_errors + 16'd1;
    end
  end
`else
  assign stat_frames = '0;
  assign stat_errors = '0;
`endif

endmodule

// File: tb/tb_xgmii_frame_tx.sv
// Directed bench for xgmii_frame_tx: one 64-bit and one 32-bit instance, every XGMII word
// logged on the falling edge and compared against hand-built expected word sequences.
module tb_xgmii_frame_tx;

`ifdef XGMII_FRAME_TX_STATS_EN
  localparam int StatsOn = 1;
`else
  localparam int StatsOn = 0;
`endif

  localparam logic [63:0] Idle64 = 64'h0707070707070707;
  localparam logic [63:0] Pre64  = 64'hD5555555555555FB;
  localparam logic [63:0] Term64 = 64'h07070707070707FD;
  localparam logic [63:0] TErr64 = 64'h07070707070707FE;
  localparam logic [63:0] Err64  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [31:0] Idle32 = 32'h07070707;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] tdata64, txd64;
  logic [7:0]  tkeep64, txc64;
  logic        tvalid64, tready64, tlast64, tuser64;
  logic [31:0] sf64;
  logic [15:0] se64;
  logic [31:0] tdata32, txd32;
  logic [3:0]  tkeep32, txc32;
  logic        tvalid32, tready32, tlast32, tuser32;
  logic [31:0] sf32;
  logic [15:0] se32;

  int chk_cnt = 0;
  int pass_cnt = 0;

  xgmii_frame_tx #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .N_IFG(12)) dut64 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata64), .s_axis_tkeep(tkeep64),
    .s_axis_tvalid(tvalid64), .s_axis_tready(tready64), .s_axis_tlast(tlast64),
    .s_axis_tuser(tuser64), .xgmii_txd(txd64), .xgmii_txc(txc64),
    .stat_frames(sf64), .stat_errors(se64)
  );

  xgmii_frame_tx #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .N_IFG(12)) dut32 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata32), .s_axis_tkeep(tkeep32),
    .s_axis_tvalid(tvalid32), .s_axis_tready(tready32), .s_axis_tlast(tlast32),
    .s_axis_tuser(tuser32), .xgmii_txd(txd32), .xgmii_txc(txc32),
    .stat_frames(sf32), .stat_errors(se32)
  );

  // Word log: entry i holds the outputs registered at the i-th rising edge.
  logic [63:0] log64_d[$];
  logic [7:0]  log64_c[$];
  logic [31:0] log32_d[$];
  logic [3:0]  log32_c[$];
  always @(negedge clk) begin
    log64_d.push_back(txd64);
    log64_c.push_back(txc64);
    log32_d.push_back(txd32);
    log32_c.push_back(txc32);
  end

  function automatic logic [63:0] mk64(input int tag, input int b);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(tag * 37 + b * 8 + j);
    return w;
  endfunction

  function automatic logic [31:0] mk32(input int tag, input int b);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(tag * 37 + b * 4 + j);
    return w;
  endfunction

  // Sends one frame on the 64-bit port; optionally drops tvalid for a cycle after a beat.
  task automatic send64(input int nbytes, input int tag, input bit user, input int stall_after);
    int nbeats, rem, waits;
    logic hs;
    nbeats = (nbytes + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      rem = nbytes - b * 8;
      tdata64  = mk64(tag, b);
      tkeep64  = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      tlast64  = (b == nbeats - 1);
      tuser64  = (b == nbeats - 1) && user;
      tvalid64 = 1'b1;
      hs = 1'b0;
      waits = 0;
      while (!hs) begin
        hs = tready64;
        @(posedge clk); #1;
        if (!hs) begin
          waits++;
          if (waits > 40) begin
            chk_cnt++;
            $display("FAIL send64 handshake: tready stuck at %0b, need 1", tready64);
            tvalid64 = 1'b0;
            return;
          end
        end
      end
      if (b == stall_after) begin
        tvalid64 = 1'b0;
        @(posedge clk); #1;
      end
    end
    tvalid64 = 1'b0;
    tlast64  = 1'b0;
    tuser64  = 1'b0;
  endtask

  task automatic send32(input int nbytes, input int tag);
    int nbeats, rem, waits;
    logic hs;
    nbeats = (nbytes + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      rem = nbytes - b * 4;
      tdata32  = mk32(tag, b);
      tkeep32  = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
      tlast32  = (b == nbeats - 1);
      tuser32  = 1'b0;
      tvalid32 = 1'b1;
      hs = 1'b0;
      waits = 0;
      while (!hs) begin
        hs = tready32;
        @(posedge clk); #1;
        if (!hs) begin
          waits++;
          if (waits > 40) begin
            chk_cnt++;
            $display("FAIL send32 handshake: tready stuck at %0b, need 1", tready32);
            tvalid32 = 1'b0;
            return;
          end
        end
      end
    end
    tvalid32 = 1'b0;
    tlast32  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tvalid64 = 1'b0; tlast64 = 1'b0; tuser64 = 1'b0; tdata64 = '0; tkeep64 = '0;
    tvalid32 = 1'b0; tlast32 = 1'b0; tuser32 = 1'b0; tdata32 = '0; tkeep32 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (txd64 !== Idle64) $display("FAIL reset txd64: got %h want %h", txd64, Idle64);
    else pass_cnt++;
    chk_cnt++;
    if (txc64 !== 8'hFF) $display("FAIL reset txc64: got %h want ff", txc64);
    else pass_cnt++;
    chk_cnt++;
    if (tready64 !== 1'b0) $display("FAIL reset tready64: got %b want 0", tready64);
    else pass_cnt++;
    chk_cnt++;
    if (sf64 !== 32'd0 || se64 !== 16'd0) $display("FAIL reset stats64: got %0d/%0d want 0/0", sf64, se64);
    else pass_cnt++;
    chk_cnt++;
    if (txd32 !== Idle32 || txc32 !== 4'hF) $display("FAIL reset out32: got %h/%h want %h/f", txd32, txc32, Idle32);
    else pass_cnt++;
    chk_cnt++;
    if (tready32 !== 1'b0) $display("FAIL reset tready32: got %b want 0", tready32);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // 64-byte, 60-byte (tkeep 0x0F) and 16-byte tuser frames offered back to back.
  task automatic test_back_to_back();
    int a;
    logic [63:0] w;
    logic [63:0] ed[$];
    logic [7:0]  ec[$];
    a = log64_d.size();
    send64(64, 1, 1'b0, -1);
    send64(60, 2, 1'b0, -1);
    send64(16, 3, 1'b1, -1);
    repeat (4) @(posedge clk);
    #1;
    ed.push_back(Pre64); ec.push_back(8'h01);
    for (int k = 0; k < 8; k++) begin ed.push_back(mk64(1, k)); ec.push_back(8'h00); end
    ed.push_back(Term64); ec.push_back(8'hFF);
    ed.push_back(Idle64); ec.push_back(8'hFF);
    ed.push_back(Pre64); ec.push_back(8'h01);
    for (int k = 0; k < 7; k++) begin ed.push_back(mk64(2, k)); ec.push_back(8'h00); end
    w = mk64(2, 7);
    ed.push_back({24'h070707, 8'hFD, w[31:0]}); ec.push_back(8'hF0);
    ed.push_back(Idle64); ec.push_back(8'hFF);
    ed.push_back(Pre64); ec.push_back(8'h01);
    ed.push_back(mk64(3, 0)); ec.push_back(8'h00);
    ed.push_back(mk64(3, 1)); ec.push_back(8'h00);
    ed.push_back(TErr64); ec.push_back(8'hFF);
    ed.push_back(Idle64); ec.push_back(8'hFF);
    for (int i = 0; i < ed.size(); i++) begin
      chk_cnt++;
      if (log64_d[a + 1 + i] !== ed[i] || log64_c[a + 1 + i] !== ec[i])
        $display("FAIL b2b word t0+%0d: got %h/%h want %h/%h", i + 1, log64_d[a + 1 + i],
                 log64_c[a + 1 + i], ed[i], ec[i]);
      else pass_cnt++;
    end
  endtask

  // tvalid drops for one cycle after the third of eight beats.
  task automatic test_underflow();
    int u;
    logic [63:0] ed[$];
    logic [7:0]  ec[$];
    u = log64_d.size();
    send64(64, 4, 1'b0, 2);
    repeat (3) @(posedge clk);
    #1;
    ed.push_back(Pre64); ec.push_back(8'h01);
    for (int k = 0; k < 3; k++) begin ed.push_back(mk64(4, k)); ec.push_back(8'h00); end
    ed.push_back(Err64); ec.push_back(8'hFF);
    for (int k = 0; k < 5; k++) begin ed.push_back(Idle64); ec.push_back(8'hFF); end
    for (int i = 0; i < ed.size(); i++) begin
      chk_cnt++;
      if (log64_d[u + 1 + i] !== ed[i] || log64_c[u + 1 + i] !== ec[i])
        $display("FAIL underflow word t0+%0d: got %h/%h want %h/%h", i + 1, log64_d[u + 1 + i],
                 log64_c[u + 1 + i], ed[i], ec[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (tready64 !== 1'b0) $display("FAIL underflow tready after drop: got %b want 0", tready64);
    else pass_cnt++;
    chk_cnt++;
    if (sf64 !== 32'(2 * StatsOn)) $display("FAIL stat_frames64: got %0d want %0d", sf64, 2 * StatsOn);
    else pass_cnt++;
    chk_cnt++;
    if (se64 !== 16'(2 * StatsOn)) $display("FAIL stat_errors64: got %0d want %0d", se64, 2 * StatsOn);
    else pass_cnt++;
  endtask

  // Two 8-byte frames on the 32-bit instance: two preamble words, two data words, /T/, IFG.
  task automatic test_width32();
    int v;
    logic [31:0] ed[$];
    logic [3:0]  ec[$];
    v = log32_d.size();
    send32(8, 5);
    send32(8, 6);
    repeat (8) @(posedge clk);
    #1;
    for (int f = 5; f < 7; f++) begin
      ed.push_back(32'h555555FB); ec.push_back(4'h1);
      ed.push_back(32'hD5555555); ec.push_back(4'h0);
      ed.push_back(mk32(f, 0)); ec.push_back(4'h0);
      ed.push_back(mk32(f, 1)); ec.push_back(4'h0);
      ed.push_back(32'h070707FD); ec.push_back(4'hF);
      ed.push_back(Idle32); ec.push_back(4'hF);
      ed.push_back(Idle32); ec.push_back(4'hF);
    end
    for (int i = 0; i < ed.size(); i++) begin
      chk_cnt++;
      if (log32_d[v + 1 + i] !== ed[i] || log32_c[v + 1 + i] !== ec[i])
        $display("FAIL width32 word t0+%0d: got %h/%h want %h/%h", i + 1, log32_d[v + 1 + i],
                 log32_c[v + 1 + i], ed[i], ec[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (sf32 !== 32'(2 * StatsOn) || se32 !== 16'd0)
      $display("FAIL stats32: got %0d/%0d want %0d/0", sf32, se32, 2 * StatsOn);
    else pass_cnt++;
  endtask

  // Reset while beat 4 is offered, then a clean 16-byte frame.
  task automatic test_reset_mid();
    int hs_cnt, cyc, w;
    logic hs;
    logic [63:0] ed[$];
    logic [7:0]  ec[$];
    tdata64 = mk64(7, 0); tkeep64 = 8'hFF; tlast64 = 1'b0; tuser64 = 1'b0; tvalid64 = 1'b1;
    hs_cnt = 0;
    cyc = 0;
    while (hs_cnt < 4 && cyc < 40) begin
      hs = tready64;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        hs_cnt++;
        tdata64 = mk64(7, hs_cnt);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (txd64 !== Idle64 || txc64 !== 8'hFF)
      $display("FAIL reset mid-frame out: got %h/%h want %h/ff", txd64, txc64, Idle64);
    else pass_cnt++;
    chk_cnt++;
    if (tready64 !== 1'b0) $display("FAIL reset mid-frame tready: got %b want 0", tready64);
    else pass_cnt++;
    rst = 1'b0;
    tvalid64 = 1'b0;
    w = log64_d.size();
    send64(16, 8, 1'b0, -1);
    repeat (4) @(posedge clk);
    #1;
    ed.push_back(Pre64); ec.push_back(8'h01);
    ed.push_back(mk64(8, 0)); ec.push_back(8'h00);
    ed.push_back(mk64(8, 1)); ec.push_back(8'h00);
    ed.push_back(Term64); ec.push_back(8'hFF);
    ed.push_back(Idle64); ec.push_back(8'hFF);
    for (int i = 0; i < ed.size(); i++) begin
      chk_cnt++;
      if (log64_d[w + 1 + i] !== ed[i] || log64_c[w + 1 + i] !== ec[i])
        $display("FAIL post-reset word t0+%0d: got %h/%h want %h/%h", i + 1, log64_d[w + 1 + i],
                 log64_c[w + 1 + i], ed[i], ec[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (sf64 !== 32'(StatsOn) || se64 !== 16'd0)
      $display("FAIL post-reset stats64: got %0d/%0d want %0d/0", sf64, se64, StatsOn);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_underflow();
    test_width32();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
